// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by bcd_bin and bin_bcd: FSM encoding, digit
// geometry and range limits.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam int HUND_W  = 2;

    localparam logic [7:0] BIN_MAX   = 8'd255;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HUND = 2'd1;
    localparam logic [1:0] ST_TENS = 2'd2;
    localparam logic [1:0] ST_ONES = 2'd3;

    function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
        return (d > DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_mul10_add.sv
// Combinational acc*10 + digit using shifts and adds only.
module bcd_mul10_add
    import bcd_pkg::*;
(
    input  logic [8:0]         acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [8:0]         result
);

    assign result = (acc << 3'd3) + (acc << 3'd1) + {5'b0_0000, digit};

endmodule

// File: rtl/bcd_bin.sv
// Sequential 3-digit BCD to 8-bit binary converter, one multiply-by-10
// accumulate step per digit (hundreds, tens, ones).
module bcd_bin
    import bcd_pkg::*;
#(
    parameter bit SAT_EN = 1'b1,
    parameter int BCD_W  = 10,
    parameter int BIN_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BCD_W-1:0] bcd_in,
    input  logic             din_vld,
    output logic             busy,
    output logic [BIN_W-1:0] bin_out,
    output logic             dout_vld,
    output logic             ovf,
    output logic             err
);

    logic [1:0]         state_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [8:0]         acc_r;
    logic               busy_r;
    logic [BIN_W-1:0]   bin_out_r;
    logic               dout_vld_r;
    logic               ovf_r;
    logic               err_r;

    logic [DIGIT_W-1:0] digit_s;
    logic [8:0]         mul_s;
    logic               err_s;
    logic               ovf_s;
    logic [BIN_W-1:0]   res_s;

    // Digit feeding the shared multiply-accumulate, chosen by the current step.
    // acc is zero in HUND, so acc*10 + hundreds reduces to the hundreds digit.
    always_comb begin
        digit_s = {DIGIT_W{1'b0}};
        case (state_r)
            ST_HUND: digit_s = {{(DIGIT_W-HUND_W){1'b0}}, bcd_r[9:8]};
            ST_TENS: digit_s = bcd_r[7:4];
            ST_ONES: digit_s = bcd_r[3:0];
            default: digit_s = {DIGIT_W{1'b0}};
        endcase
    end

    bcd_mul10_add u_mul10 (
        .acc    (acc_r),
        .digit  (digit_s),
        .result (mul_s)
    );

    assign err_s = digit_bad(bcd_r[7:4]) | digit_bad(bcd_r[3:0]);

    // Final result shaping: an invalid digit forces a clean zero result.
    always_comb begin
        ovf_s = 1'b0;
        res_s = mul_s[7:0];
        if (err_s) begin
            ovf_s = 1'b0;
            res_s = {BIN_W{1'b0}};
        end else if (mul_s > {1'b0, BIN_MAX}) begin
            ovf_s = 1'b1;
            res_s = SAT_EN ? BIN_MAX : mul_s[7:0];
        end else begin
            ovf_s = 1'b0;
            res_s = mul_s[7:0];
        end
    end

    // Conversion FSM and registered outputs; din_vld only matters in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            bcd_r      <= {BCD_W{1'b0}};
            acc_r      <= 9'd0;
            busy_r     <= 1'b0;
            bin_out_r  <= {BIN_W{1'b0}};
            dout_vld_r <= 1'b0;
            ovf_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            dout_vld_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (din_vld) begin
                        bcd_r   <= bcd_in;
                        acc_r   <= 9'd0;
                        busy_r  <= 1'b1;
                        state_r <= ST_HUND;
                    end
                end
                ST_HUND: begin
                    acc_r   <= mul_s;
                    state_r <= ST_TENS;
                end
                ST_TENS: begin
                    acc_r   <= mul_s;
                    state_r <= ST_ONES;
                end
                ST_ONES: begin
                    bin_out_r  <= res_s;
                    ovf_r      <= ovf_s;
                    err_r      <= err_s;
                    dout_vld_r <= 1'b1;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign bin_out  = bin_out_r;
    assign dout_vld = dout_vld_r;
    assign ovf      = ovf_r;
    assign err      = err_r;

endmodule
